// File: rtl/operand_feeder.sv
// operand_feeder: buffers one MATRIX_SIZE x MATRIX_SIZE operand matrix column
// by column, then replays the columns into the input skew stage of a systolic
// array, followed by MATRIX_SIZE-1 zero columns that drain the deepest skew row.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   in_valid/in_ready   column-beat handshake (ready only while loading)
//   in_data[i]          row i element of the incoming column
//   stall               downstream hold for streaming/flushing
//   data_out[i]         lane i drives row i of the skew stage (zero when idle)
//   enable_out          skew-stage shift enable; data_out valid when high
//   busy                high while a loaded matrix is being streamed out
//   done                one-cycle pulse after the last flush beat

// Per-row storage: one element per column slot, read gated to zero.
module operand_feeder_lane #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32,
  parameter int IW          = 1
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [IW-1:0]        wr_idx,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [IW-1:0]        rd_idx,
  output logic [DATA_SIZE-1:0] data_out
);
  // No reset: stale contents are never read before the next full load.
  logic [DATA_SIZE-1:0] mem [MATRIX_SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign data_out = rd_en ? mem[rd_idx] : '0;
endmodule

module operand_feeder #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data [MATRIX_SIZE],
  input  logic                 stall,
  output logic [DATA_SIZE-1:0] data_out [MATRIX_SIZE],
  output logic                 enable_out,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = ($clog2(MATRIX_SIZE + 1) > 1) ? $clog2(MATRIX_SIZE + 1) : 1;
  localparam int IW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

  localparam logic [CW-1:0] LAST       = CW'(MATRIX_SIZE - 1);
  localparam logic [CW-1:0] FLUSH_LAST = (MATRIX_SIZE > 1) ? CW'(MATRIX_SIZE - 2) : '0;

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] load_cnt;
  logic [CW-1:0] stream_cnt;   // reused as the flush beat counter
  logic          accept;
  logic          rd_en;

  assign in_ready   = (state == S_LOAD);
  assign accept     = in_valid && in_ready;
  assign enable_out = ((state == S_STREAM) || (state == S_FLUSH)) && !stall;
  assign busy       = (state != S_LOAD);
  assign done       = (state == S_DONE);
  // Flush beats read nothing, so the lanes output zeros then.
  assign rd_en      = (state == S_STREAM) && !stall;

  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    operand_feeder_lane #(
      .MATRIX_SIZE(MATRIX_SIZE),
      .DATA_SIZE  (DATA_SIZE),
      .IW         (IW)
    ) u_lane (
      .clk     (clk),
      .wr_en   (accept && !reset),
      .wr_idx  (load_cnt[IW-1:0]),
      .wr_data (in_data[i]),
      .rd_en   (rd_en),
      .rd_idx  (stream_cnt[IW-1:0]),
      .data_out(data_out[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LOAD;
      load_cnt   <= '0;
      stream_cnt <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (accept) begin
            if (load_cnt == LAST) begin
              load_cnt <= '0;
              state    <= S_STREAM;
            end else begin
              load_cnt <= load_cnt + CW'(1);
            end
          end
        end
        S_STREAM: begin
          if (enable_out) begin
            if (stream_cnt == LAST) begin
              stream_cnt <= '0;
              // A single row has no skew to drain.
              state      <= (MATRIX_SIZE == 1) ? S_DONE : S_FLUSH;
            end else begin
              stream_cnt <= stream_cnt + CW'(1);
            end
          end
        end
        S_FLUSH: begin
          if (enable_out) begin
            if (stream_cnt == FLUSH_LAST) begin
              stream_cnt <= '0;
              state      <= S_DONE;
            end else begin
              stream_cnt <= stream_cnt + CW'(1);
            end
          end
        end
        default: begin
          state      <= S_LOAD;
          load_cnt   <= '0;
          stream_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_operand_feeder.sv
// Bench for operand_feeder (MATRIX_SIZE=2 main instance, MATRIX_SIZE=1 side
// instance). Accepted beats are pushed to a scoreboard along with the flush
// zero column; every enabled output beat pops and compares one entry.
module tb_operand_feeder;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, stall;
  logic        in_ready, enable_out, busy, done;
  logic [31:0] in_data  [2];
  logic [31:0] data_out [2];

  logic        in_valid1, in_ready1, enable_out1, busy1, done1;
  logic [31:0] in_data1  [1];
  logic [31:0] data_out1 [1];

  int checks = 0;
  int failures = 0;
  logic [63:0] sb_q[$];
  int nbeats = 0;

  always #5 clk = ~clk;

  operand_feeder #(.MATRIX_SIZE(2), .DATA_SIZE(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .stall(stall), .data_out(data_out),
    .enable_out(enable_out), .busy(busy), .done(done)
  );

  operand_feeder #(.MATRIX_SIZE(1), .DATA_SIZE(32)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .stall(1'b0), .data_out(data_out1),
    .enable_out(enable_out1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [31:0] r0, input logic [31:0] r1);
    return {r1, r0};
  endfunction

  // Scoreboard producer: an accepted beat is the next streamed column; the
  // second beat of a matrix is followed by one zero flush column.
  always @(posedge clk) begin
    if (reset) begin
      sb_q.delete();
      nbeats = 0;
    end else if (in_valid && in_ready) begin
      sb_q.push_back(pk(in_data[0], in_data[1]));
      nbeats++;
      if (nbeats == 2) begin
        sb_q.push_back(64'd0);
        nbeats = 0;
      end
    end
  end

  // Scoreboard consumer plus zero-when-disabled check.
  always @(negedge clk) begin
    if (!reset) begin
      if (enable_out) begin
        if (sb_q.size() == 0) chk("sb_extra_beat", 64'd1, 64'd0);
        else chk("sb_data", pk(data_out[0], data_out[1]), sb_q.pop_front());
      end else begin
        chk("idle_zero", pk(data_out[0], data_out[1]), 64'd0);
      end
    end
  end

  task automatic drv(input bit v, input logic [31:0] a, input logic [31:0] b, input bit s);
    in_valid   = v;
    in_data[0] = a;
    in_data[1] = b;
    stall      = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the current cycle's outputs, then advance to the next cycle.
  task automatic exp_cyc(input string tag, input bit en, input logic [63:0] d,
                         input bit dn, input bit rdy);
    @(negedge clk);
    chk({tag, ".en"},    {63'd0, enable_out}, {63'd0, en});
    chk({tag, ".data"},  pk(data_out[0], data_out[1]), d);
    chk({tag, ".done"},  {63'd0, done}, {63'd0, dn});
    chk({tag, ".ready"}, {63'd0, in_ready}, {63'd0, rdy});
    chk({tag, ".busy"},  {63'd0, busy}, {63'd0, !rdy});
    tick();
  endtask

  initial begin
    reset = 1'b1;
    in_valid1 = 1'b0;
    in_data1[0] = '0;
    drv(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    exp_cyc("rst", 0, 0, 0, 1);

    // Basic matrix, no stall
    drv(1, 1, 2, 0); exp_cyc("b0", 0, 0, 0, 1);
    drv(1, 3, 4, 0); exp_cyc("b1", 0, 0, 0, 1);
    drv(0, 0, 0, 0); exp_cyc("b2", 1, pk(1, 2), 0, 0);
    exp_cyc("b3", 1, pk(3, 4), 0, 0);
    exp_cyc("b4", 1, 0, 0, 0);
    exp_cyc("b5", 0, 0, 1, 0);
    exp_cyc("b6", 0, 0, 0, 1);

    // Stall during streaming
    drv(1, 1, 2, 0); exp_cyc("s0", 0, 0, 0, 1);
    drv(1, 3, 4, 0); exp_cyc("s1", 0, 0, 0, 1);
    drv(0, 0, 0, 0); exp_cyc("s2", 1, pk(1, 2), 0, 0);
    drv(0, 0, 0, 1); exp_cyc("s3", 0, 0, 0, 0);
    drv(0, 0, 0, 0); exp_cyc("s4", 1, pk(3, 4), 0, 0);
    exp_cyc("s5", 1, 0, 0, 0);
    exp_cyc("s6", 0, 0, 1, 0);
    exp_cyc("s7", 0, 0, 0, 1);

    // Gaps between beats; stall in LOAD and DONE is ignored
    drv(1, 5, 6, 0); exp_cyc("g0", 0, 0, 0, 1);
    drv(0, 0, 0, 1); exp_cyc("g1", 0, 0, 0, 1);
    drv(0, 0, 0, 0); exp_cyc("g2", 0, 0, 0, 1);
    drv(1, 7, 8, 0); exp_cyc("g3", 0, 0, 0, 1);
    drv(0, 0, 0, 0); exp_cyc("g4", 1, pk(5, 6), 0, 0);
    exp_cyc("g5", 1, pk(7, 8), 0, 0);
    exp_cyc("g6", 1, 0, 0, 0);
    drv(0, 0, 0, 1); exp_cyc("g7", 0, 0, 1, 0);
    drv(0, 0, 0, 0); exp_cyc("g8", 0, 0, 0, 1);

    // Upstream keeps presenting {9,9} while busy
    drv(1, 1, 2, 0); exp_cyc("v0", 0, 0, 0, 1);
    drv(1, 3, 4, 0); exp_cyc("v1", 0, 0, 0, 1);
    drv(1, 9, 9, 0); exp_cyc("v2", 1, pk(1, 2), 0, 0);
    exp_cyc("v3", 1, pk(3, 4), 0, 0);
    exp_cyc("v4", 1, 0, 0, 0);
    exp_cyc("v5", 0, 0, 1, 0);
    drv(0, 0, 0, 0); exp_cyc("v6", 0, 0, 0, 1);

    // Reset mid-stream abandons the matrix
    drv(1, 1, 2, 0); exp_cyc("r0", 0, 0, 0, 1);
    drv(1, 3, 4, 0); exp_cyc("r1", 0, 0, 0, 1);
    drv(0, 0, 0, 0); exp_cyc("r2", 1, pk(1, 2), 0, 0);
    reset = 1'b1;    exp_cyc("r3", 1, pk(3, 4), 0, 0);
    reset = 1'b0;
    drv(1, 10, 11, 0); exp_cyc("r4", 0, 0, 0, 1);
    drv(1, 12, 13, 0); exp_cyc("r5", 0, 0, 0, 1);
    drv(0, 0, 0, 0);   exp_cyc("r6", 1, pk(10, 11), 0, 0);
    exp_cyc("r7", 1, pk(12, 13), 0, 0);
    exp_cyc("r8", 1, 0, 0, 0);
    exp_cyc("r9", 0, 0, 1, 0);
    exp_cyc("r10", 0, 0, 0, 1);

    // A beat presented together with reset is not accepted
    drv(1, 20, 21, 0); reset = 1'b1; exp_cyc("p0", 0, 0, 0, 1);
    reset = 1'b0;
    drv(1, 22, 23, 0); exp_cyc("p1", 0, 0, 0, 1);
    drv(1, 24, 25, 0); exp_cyc("p2", 0, 0, 0, 1);
    drv(0, 0, 0, 0);   exp_cyc("p3", 1, pk(22, 23), 0, 0);
    exp_cyc("p4", 1, pk(24, 25), 0, 0);
    exp_cyc("p5", 1, 0, 0, 0);
    exp_cyc("p6", 0, 0, 1, 0);
    exp_cyc("p7", 0, 0, 0, 1);

    // Single-row build: stream one beat, no flush
    in_valid1 = 1'b1; in_data1[0] = 32'd7;
    @(negedge clk);
    chk("m1_0.ready", {63'd0, in_ready1}, 64'd1);
    chk("m1_0.en",    {63'd0, enable_out1}, 64'd0);
    tick();
    in_valid1 = 1'b1; in_data1[0] = 32'd99;
    @(negedge clk);
    chk("m1_1.en",    {63'd0, enable_out1}, 64'd1);
    chk("m1_1.data",  {32'd0, data_out1[0]}, 64'd7);
    chk("m1_1.done",  {63'd0, done1}, 64'd0);
    chk("m1_1.busy",  {63'd0, busy1}, 64'd1);
    tick();
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("m1_2.en",    {63'd0, enable_out1}, 64'd0);
    chk("m1_2.done",  {63'd0, done1}, 64'd1);
    chk("m1_2.data",  {32'd0, data_out1[0]}, 64'd0);
    tick();
    @(negedge clk);
    chk("m1_3.ready", {63'd0, in_ready1}, 64'd1);
    chk("m1_3.done",  {63'd0, done1}, 64'd0);
    chk("m1_3.busy",  {63'd0, busy1}, 64'd0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
